// File: rtl/mem_dma_pkg.sv
// rtl/mem_dma_pkg.sv - shared codes, register map, status bits and FSM encoding for mem_dma
package mem_dma_pkg;

  localparam logic [1:0] CTL_NOP   = 2'd0;
  localparam logic [1:0] CTL_READ  = 2'd1;
  localparam logic [1:0] CTL_WRITE = 2'd2;

  localparam logic [1:0] MEM_NOP   = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  localparam logic [31:0] REG_CTRL        = 32'd0;
  localparam logic [31:0] REG_EXT_ADDR_LO = 32'd1;
  localparam logic [31:0] REG_EXT_ADDR_HI = 32'd2;
  localparam logic [31:0] REG_INT_ADDR    = 32'd3;
  localparam logic [31:0] REG_LEN         = 32'd4;
  localparam logic [31:0] REG_STATUS      = 32'd5;

  localparam int CTRL_START = 0;
  localparam int CTRL_DIR   = 1;
  localparam int CTRL_ABORT = 2;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERR     = 2;
  localparam int ST_ABORTED = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_XRD  = 3'd1,
    S_IWR  = 3'd2,
    S_IRD  = 3'd3,
    S_CAP  = 3'd4,
    S_XWR  = 3'd5,
    S_DONE = 3'd6
  } state_t;

endpackage

// File: rtl/mem_dma_regs.sv
// rtl/mem_dma_regs.sv - host register file, sticky STATUS bits and registered read-data mux
module mem_dma_regs
  import mem_dma_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int LEN_W  = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        reg_ctl,
  input  logic [31:0]       reg_addr,
  input  logic [31:0]       reg_data,
  output logic [31:0]       reg_rdata,
  input  logic              busy,
  input  logic              set_done,
  input  logic              set_aborted,
  output logic              start,
  output logic              abort,
  output logic              dir,
  output logic [63:0]       ext_addr,
  output logic [ADDR_W-1:0] int_addr,
  output logic [LEN_W-1:0]  len
);

  logic        wr, rd, ctrl_wr, start_req, set_err;
  logic [3:1]  clr;
  logic [31:0] ext_lo, ext_hi, rnext;
  logic        done, err, aborted;

  assign wr        = (reg_ctl == CTL_WRITE);
  assign rd        = (reg_ctl == CTL_READ);
  assign ctrl_wr   = wr && (reg_addr == REG_CTRL);
  // abort in the same write as start suppresses the start entirely
  assign abort     = ctrl_wr && reg_data[CTRL_ABORT];
  assign start_req = ctrl_wr && reg_data[CTRL_START] && !reg_data[CTRL_ABORT];
  assign start     = start_req && !busy;
  assign set_err   = start_req && busy;
  assign dir       = reg_data[CTRL_DIR];
  assign clr       = (wr && (reg_addr == REG_STATUS)) ? reg_data[3:1] : 3'd0;
  assign ext_addr  = {ext_hi, ext_lo};

  // config registers: always writable, sampled by the sequencer only at start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_lo   <= '0;
      ext_hi   <= '0;
      int_addr <= '0;
      len      <= '0;
    end else if (wr) begin
      if (reg_addr == REG_EXT_ADDR_LO) ext_lo   <= reg_data;
      if (reg_addr == REG_EXT_ADDR_HI) ext_hi   <= reg_data;
      if (reg_addr == REG_INT_ADDR)    int_addr <= reg_data[ADDR_W-1:0];
      if (reg_addr == REG_LEN)         len      <= reg_data[LEN_W-1:0];
    end
  end

  // sticky status bits; a hardware set beats a host clear in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      err     <= 1'b0;
      aborted <= 1'b0;
    end else begin
      done    <= set_done    | (done    & ~clr[ST_DONE]);
      err     <= set_err     | (err     & ~clr[ST_ERR]);
      aborted <= set_aborted | (aborted & ~clr[ST_ABORTED]);
    end
  end

  // read mux; unmapped offsets and write-only CTRL return zero
  always_comb begin
    rnext = '0;
    case (reg_addr)
      REG_EXT_ADDR_LO: rnext = ext_lo;
      REG_EXT_ADDR_HI: rnext = ext_hi;
      REG_INT_ADDR:    rnext = 32'(int_addr);
      REG_LEN:         rnext = 32'(len);
      REG_STATUS:      rnext = {28'd0, aborted, err, done, busy};
      default:         rnext = '0;
    endcase
  end

  // host read data only changes on a READ access
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     reg_rdata <= '0;
    else if (rd) reg_rdata <= rnext;
  end

endmodule

// File: rtl/mem_dma.sv
// rtl/mem_dma.sv - single-word-in-flight DMA sequencer between external memory and an internal mem port (option: MEM_DMA_IRQ_EN)
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int          ADDR_W     = 13,
  parameter int          DATA_W     = 64,
  parameter int          LEN_W      = 14,
  parameter logic [63:0] EXT_STRIDE = 64'd8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_reg_ctl,
  input  logic [31:0]       i_reg_addr,
  input  logic [31:0]       i_reg_data,
  output logic [31:0]       o_reg_data,
  output logic              o_read_en,
  output logic [63:0]       o_read_addr,
  input  logic              i_read_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_write_en,
  output logic [63:0]       o_write_addr,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_write_ready,
  output logic [1:0]        o_mem_op,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_irq
);

  state_t            state, next;
  logic              start, abort, dir, busy, active, abort_pend;
  logic [63:0]       cfg_ext, ext_cnt;
  logic [ADDR_W-1:0] cfg_int, int_cnt;
  logic [LEN_W-1:0]  cfg_len, rem;
  logic [DATA_W-1:0] mem_wdata, ext_wdata;
  logic              last;

  assign busy   = (state != S_IDLE);
  assign active = busy && (state != S_DONE);
  assign last   = (rem == LEN_W'(1));

  mem_dma_regs #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_regs (
    .clk         (i_clk),
    .rst         (i_rst),
    .reg_ctl     (i_reg_ctl),
    .reg_addr    (i_reg_addr),
    .reg_data    (i_reg_data),
    .reg_rdata   (o_reg_data),
    .busy        (busy),
    .set_done    (state == S_DONE),
    .set_aborted (abort && active),
    .start       (start),
    .abort       (abort),
    .dir         (dir),
    .ext_addr    (cfg_ext),
    .int_addr    (cfg_int),
    .len         (cfg_len)
  );

  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= next;
  end

  // next state; a handshake coinciding with abort still finishes its beat
  always_comb begin
    next = state;
    case (state)
      S_IDLE: if (start) next = (cfg_len == '0) ? S_DONE : (dir ? S_IRD : S_XRD);
      S_XRD:  if (i_read_valid) next = S_IWR;
              else if (abort) next = S_IDLE;
      S_IWR:  if (abort || abort_pend) next = S_IDLE;
              else next = last ? S_DONE : S_XRD;
      S_IRD:  next = abort ? S_IDLE : S_CAP;
      S_CAP:  next = abort ? S_IDLE : S_XWR;
      S_XWR:  if (i_write_ready) next = abort ? S_IDLE : (last ? S_DONE : S_IRD);
              else if (abort) next = S_IDLE;
      S_DONE: next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  // working counters and data holding registers, loaded from config at start
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ext_cnt    <= '0;
      int_cnt    <= '0;
      rem        <= '0;
      mem_wdata  <= '0;
      ext_wdata  <= '0;
      abort_pend <= 1'b0;
    end else begin
      abort_pend <= (state == S_XRD) && i_read_valid && abort;
      case (state)
        S_IDLE: if (start) begin
          ext_cnt <= cfg_ext;
          int_cnt <= cfg_int;
          rem     <= cfg_len;
        end
        S_XRD: if (i_read_valid) begin
          mem_wdata <= i_data;
          ext_cnt   <= ext_cnt + EXT_STRIDE;
        end
        S_IWR: begin
          int_cnt <= int_cnt + 1'b1;
          rem     <= rem - 1'b1;
        end
        S_IRD: int_cnt <= int_cnt + 1'b1;
        S_CAP: ext_wdata <= i_mem_data;
        S_XWR: if (i_write_ready) begin
          ext_cnt <= ext_cnt + EXT_STRIDE;
          rem     <= rem - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_read_en    = (state == S_XRD);
  assign o_read_addr  = ext_cnt;
  assign o_write_en   = (state == S_XWR);
  assign o_write_addr = ext_cnt;
  assign o_data       = ext_wdata;
  assign o_mem_op     = (state == S_IWR) ? MEM_WRITE : ((state == S_IRD) ? MEM_READ : MEM_NOP);
  assign o_mem_addr   = int_cnt;
  assign o_mem_data   = mem_wdata;

`ifdef MEM_DMA_IRQ_EN
  assign o_irq = (state == S_DONE);
`else
  assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_mem_dma.sv
// tb/tb_mem_dma.sv - directed self-checking bench for mem_dma
module tb_mem_dma;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [1:0]  i_reg_ctl;
  logic [31:0] i_reg_addr, i_reg_data;
  logic [31:0] o_reg_data;
  logic        o_read_en, o_write_en, o_irq;
  logic [63:0] o_read_addr, o_write_addr, o_data, o_mem_data, i_data, i_mem_data;
  logic        i_read_valid = 1'b0;
  logic        i_write_ready = 1'b0;
  logic [1:0]  o_mem_op;
  logic [12:0] o_mem_addr;
  logic [12:0] mem_addr_d = '0;

  int n_chk = 0, n_pass = 0;
  int rd_dly = 2, wr_base = 0, wr_stall1 = 0;
  int rcnt = 0, wcnt = 0, irq_cnt = 0, traffic = 0;
  logic [63:0] rd_q[$], mw_a[$], mw_d[$], mr_a[$], xw_a[$], xw_d[$];
  localparam logic [63:0] BAD = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 i_clk = ~i_clk;

  assign i_data     = 64'hBEEF_0000_0000_0000 ^ o_read_addr;
  assign i_mem_data = 64'hCAFE_0000_0000_0000 | 64'(mem_addr_d);

  mem_dma dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_reg_ctl(i_reg_ctl), .i_reg_addr(i_reg_addr),
    .i_reg_data(i_reg_data), .o_reg_data(o_reg_data), .o_read_en(o_read_en),
    .o_read_addr(o_read_addr), .i_read_valid(i_read_valid), .i_data(i_data),
    .o_write_en(o_write_en), .o_write_addr(o_write_addr), .o_data(o_data),
    .i_write_ready(i_write_ready), .o_mem_op(o_mem_op), .o_mem_addr(o_mem_addr),
    .o_mem_data(o_mem_data), .i_mem_data(i_mem_data), .o_irq(o_irq)
  );

  // external read responder: valid after rd_dly cycles of request
  always @(posedge i_clk) begin
    i_read_valid <= 1'b0;
    if (!o_read_en) rcnt <= 0;
    else if (!i_read_valid) begin
      if (rcnt >= rd_dly) begin i_read_valid <= 1'b1; rcnt <= 0; end
      else rcnt <= rcnt + 1;
    end
  end

  // external write responder: beat 1 may use a distinct stall
  always @(posedge i_clk) begin
    i_write_ready <= 1'b0;
    if (!o_write_en) wcnt <= 0;
    else if (!i_write_ready) begin
      if (wcnt >= ((xw_a.size() == 1) ? wr_stall1 : wr_base)) begin i_write_ready <= 1'b1; wcnt <= 0; end
      else wcnt <= wcnt + 1;
    end
  end

  // traffic monitor and internal read-port model
  always @(posedge i_clk) begin
    mem_addr_d <= o_mem_addr;
    if (o_irq) irq_cnt <= irq_cnt + 1;
    if (o_read_en || o_write_en || o_mem_op != 2'd0) traffic <= traffic + 1;
    if (o_read_en && i_read_valid) rd_q.push_back(o_read_addr);
    if (o_mem_op == 2'd2) begin mw_a.push_back(64'(o_mem_addr)); mw_d.push_back(o_mem_data); end
    if (o_mem_op == 2'd1) mr_a.push_back(64'(o_mem_addr));
    if (o_write_en && i_write_ready) begin xw_a.push_back(o_write_addr); xw_d.push_back(o_data); end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic reg_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge i_clk);
    i_reg_ctl = 2'd2; i_reg_addr = a; i_reg_data = d;
    @(negedge i_clk);
    i_reg_ctl = 2'd0;
  endtask

  task automatic reg_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge i_clk);
    i_reg_ctl = 2'd1; i_reg_addr = a;
    @(negedge i_clk);
    i_reg_ctl = 2'd0;
    d = o_reg_data;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      reg_rd(32'd5, s);
      ok = !s[0];
    end
    chk({tag, "_idle"}, 64'(ok), 64'd1);
  endtask

  task automatic clear_q();
    rd_q.delete(); mw_a.delete(); mw_d.delete(); mr_a.delete(); xw_a.delete(); xw_d.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] s;
    logic [63:0] ea[3];
    logic [63:0] ia[3];
    int t0;
    bit found;
    i_rst = 1'b1; i_reg_ctl = 2'd0; i_reg_addr = '0; i_reg_data = '0;
    repeat (3) @(negedge i_clk);
    chk("rst_read_en", 64'(o_read_en), 64'd0);
    chk("rst_write_en", 64'(o_write_en), 64'd0);
    chk("rst_mem_op", 64'(o_mem_op), 64'd0);
    chk("rst_reg_data", 64'(o_reg_data), 64'd0);
    chk("rst_irq", 64'(o_irq), 64'd0);
    i_rst = 1'b0;
    reg_rd(32'd5, s); chk("rst_status", 64'(s), 64'd0);
    reg_rd(32'd4, s); chk("rst_len", 64'(s), 64'd0);

    // ext->int, 4 words
    clear_q(); rd_dly = 2;
    reg_wr(32'd1, 32'h1000); reg_wr(32'd2, 32'd0); reg_wr(32'd3, 32'h10); reg_wr(32'd4, 32'd4);
    reg_wr(32'd0, 32'd1);
    wait_idle("x2i");
    reg_rd(32'd5, s); chk("x2i_status", 64'(s), 64'h2);
    chk("x2i_nrd", 64'(rd_q.size()), 64'd4);
    chk("x2i_nmw", 64'(mw_a.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("x2i_rdaddr%0d", i), (i < rd_q.size()) ? rd_q[i] : BAD, 64'h1000 + 64'(8 * i));
      chk($sformatf("x2i_mwaddr%0d", i), (i < mw_a.size()) ? mw_a[i] : BAD, 64'h10 + 64'(i));
      chk($sformatf("x2i_mwdata%0d", i), (i < mw_d.size()) ? mw_d[i] : BAD,
          64'hBEEF_0000_0000_0000 ^ (64'h1000 + 64'(8 * i)));
    end
    reg_rd(32'd4, s); chk("rd_len", 64'(s), 64'd4);
    reg_rd(32'd9, s); chk("rd_unmapped", 64'(s), 64'd0);

    // int->ext, wrapping internal address, stall on beat 1
    reg_wr(32'd5, 32'hE);
    clear_q(); wr_base = 0; wr_stall1 = 3;
    reg_wr(32'd3, 32'h1FFE); reg_wr(32'd4, 32'd3); reg_wr(32'd1, 32'h40);
    reg_wr(32'd0, 32'd3);
    wait_idle("i2x");
    reg_rd(32'd5, s); chk("i2x_status", 64'(s), 64'h2);
    ia[0] = 64'h1FFE; ia[1] = 64'h1FFF; ia[2] = 64'h0;
    ea[0] = 64'h40;   ea[1] = 64'h48;   ea[2] = 64'h50;
    chk("i2x_nxw", 64'(xw_a.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("i2x_mraddr%0d", i), (i < mr_a.size()) ? mr_a[i] : BAD, ia[i]);
      chk($sformatf("i2x_xwaddr%0d", i), (i < xw_a.size()) ? xw_a[i] : BAD, ea[i]);
      chk($sformatf("i2x_xwdata%0d", i), (i < xw_d.size()) ? xw_d[i] : BAD, 64'hCAFE_0000_0000_0000 | ia[i]);
    end

    // LEN=0: immediate done, no traffic
    reg_wr(32'd5, 32'hE);
    t0 = traffic;
    reg_wr(32'd4, 32'd0); reg_wr(32'd0, 32'd1);
    reg_rd(32'd5, s); chk("len0_status", 64'(s), 64'h2);
    chk("len0_traffic", 64'(traffic - t0), 64'd0);

    // start while busy sets err, transfer unaffected
    reg_wr(32'd5, 32'hE);
    clear_q();
    reg_wr(32'd1, 32'h3000); reg_wr(32'd3, 32'h20); reg_wr(32'd4, 32'd3);
    reg_wr(32'd0, 32'd1); reg_wr(32'd0, 32'd1);
    wait_idle("busy");
    reg_rd(32'd5, s); chk("busy_status", 64'(s), 64'h6);
    chk("busy_nmw", 64'(mw_a.size()), 64'd3);
    chk("busy_mwaddr2", (mw_a.size() > 2) ? mw_a[2] : BAD, 64'h22);
    chk("busy_rdaddr2", (rd_q.size() > 2) ? rd_q[2] : BAD, 64'h3010);
    reg_wr(32'd5, 32'hE);
    reg_rd(32'd5, s); chk("clr_status", 64'(s), 64'h0);

    // abort in XRD after 2 of 8 words
    clear_q();
    reg_wr(32'd1, 32'h2000); reg_wr(32'd3, 32'h100); reg_wr(32'd4, 32'd8);
    reg_wr(32'd0, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge i_clk);
      found = (mw_a.size() >= 2);
    end
    chk("abort_reach2", 64'(found), 64'd1);
    reg_wr(32'd0, 32'd4);
    chk("abort_read_en", 64'(o_read_en), 64'd0);
    repeat (3) @(negedge i_clk);
    chk("abort_nmw", 64'(mw_a.size()), 64'd2);
    chk("abort_mem_op", 64'(o_mem_op), 64'd0);
    reg_rd(32'd5, s); chk("abort_status", 64'(s), 64'h8);
`ifdef MEM_DMA_IRQ_EN
    chk("irq_count", 64'(irq_cnt), 64'd4);
`else
    chk("irq_count", 64'(irq_cnt), 64'd0);
`endif

    // asynchronous reset while in XWR
    clear_q(); wr_base = 50; wr_stall1 = 50;
    reg_wr(32'd3, 32'h5); reg_wr(32'd4, 32'd2); reg_wr(32'd1, 32'h80);
    reg_wr(32'd0, 32'd3);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge i_clk);
      found = o_write_en;
    end
    chk("xwr_reach", 64'(found), 64'd1);
    chk("xwr_data", o_data, 64'hCAFE_0000_0000_0005);
    i_rst = 1'b1;
    #1;
    chk("arst_write_en", 64'(o_write_en), 64'd0);
    chk("arst_write_addr", o_write_addr, 64'd0);
    chk("arst_data", o_data, 64'd0);
    chk("arst_mem_op", 64'(o_mem_op), 64'd0);
    chk("arst_read_en", 64'(o_read_en), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    reg_rd(32'd5, s); chk("arst_status", 64'(s), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
